fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-domain pointer and flag controller for the asynchronous FIFO. It accepts write requests and generates the binary RAM write address. It also produces the registered Gray-coded write pointer that is passed to the read domain through a two-flop synchronizer. From the read pointer that has already been synchronized into the write domain, it derives full, almost-full, occupancy and sticky overflow status.

## Interface

Parameters:
- ADDR_WIDTH, 4, RAM address width. Depth = 2^ADDR_WIDTH. Must be >= 2. Pointers are ADDR_WIDTH+1 bits.
- AF_THRESH, 12, occupancy at or above which w_almost_full asserts. Range 1..2^ADDR_WIDTH.

Ports:
- clk  in  1  write-domain clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- rq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into the clk domain.
- w_accept  out  1  write enable to RAM: w_en & ~w_full & ~rst (combinational).
- w_addr  out  ADDR_WIDTH  binary RAM write address, registered.
- w_ptr  out  ADDR_WIDTH+1  Gray write pointer to the read-domain synchronizer, registered.
- w_full  out  1  FIFO full, registered.
- w_almost_full  out  1  occupancy >= AF_THRESH, registered.
- w_level  out  ADDR_WIDTH+1  occupancy as seen from the write side (0..2^ADDR_WIDTH), registered.
- w_overflow  out  1  sticky; set by a write attempt while full.

## Operation

- Internal state is the binary pointer wbin (ADDR_WIDTH+1 bits).
- Next pointer: wbin_next = wbin + w_accept, modulo 2^(ADDR_WIDTH+1).
- Gray conversion: wgray_next = (wbin_next >> 1) ^ wbin_next.
- Registered outputs on each edge:
  - wbin <= wbin_next
  - w_ptr <= wgray_next
  - w_addr = wbin[ADDR_WIDTH-1:0], taken directly from the register.
- w_ptr is driven straight from a flop with no output logic. It changes by exactly one bit per accepted write and is unchanged otherwise.
- Full: w_full <= (wgray_next == {~rq2_rptr[A:A-1], rq2_rptr[A-2:0]}), where A = ADDR_WIDTH.
- Occupancy:
  - rbin = Gray-to-binary(rq2_rptr), using an XOR prefix from the MSB.
  - w_level <= (wbin_next - rbin) mod 2^(A+1).
  - w_almost_full <= (that same value >= AF_THRESH).
- Overflow: w_overflow <= w_overflow | (w_en & w_full). When w_en is asserted while w_full is high:
  - w_accept = 0
  - wbin, w_ptr and w_addr hold.
  - Overflow is cleared only by rst.
- Flags are pessimistic by design. rq2_rptr lags the true read pointer by the synchronizer latency, so full/level may overstate occupancy but never understate it.
- Reset: rst high at a posedge clears wbin, w_addr, w_ptr, w_full, w_almost_full, w_level and w_overflow to 0. w_accept is 0 while rst is high, regardless of w_en.
- Reset mid-operation discards all pointer state. The read domain must be reset in the same system reset event; this is not checked here.

## Timing

- A write is accepted in cycle N (w_accept=1): the RAM writes at w_addr during cycle N.
- After edge N:
  - w_addr and w_ptr show the advanced pointer.
  - w_level, w_full and w_almost_full include that write.
- Full asserts on the edge that accepts the 2^A-th outstanding write. There is no one-cycle window in which an extra write can slip through.
- A change on rq2_rptr in cycle N is reflected in w_full, w_level and w_almost_full after edge N.
- A write and an rq2_rptr change in the same cycle are both folded into the next values. For example, at level 15 with a write and a read advance together, the level stays 15 and full stays low.
- Wrap-around:
  - wbin goes from 2^(A+1)-1 to 0.
  - w_ptr goes from Gray(2^(A+1)-1) = 10…0 to 0…0, a single-bit change.
  - Full and level arithmetic stays correct across the wrap because it is modulo.

## Test plan

1. **Reset.** Assert rst for 2 cycles with w_en=1.
   - Required: all outputs 0 and w_accept=0 throughout; w_accept follows w_en on the first cycle after rst drops.
2. **Fill** (A=4, rq2_rptr=0). Apply 16 back-to-back writes.
   - Required: w_addr steps 0..15.
   - Required: w_ptr steps 0,1,3,2,6,7,5,4,12,… with exactly one bit changing per step.
   - Required: w_almost_full rises after the 12th write, with w_level=12.
   - Required: w_full rises after the 16th write, with w_level=16.
3. **Overflow.** Hold w_en=1 for 3 further cycles while full.
   - Required: w_accept=0 and w_ptr holds at Gray(16)=11000.
   - Required: w_overflow=1, and it stays 1 after w_en drops, until rst.
4. **Drain.** Drive rq2_rptr=Gray(4)=00110.
   - Required next cycle: w_full=0, w_level=12, w_almost_full=1.
   - Then drive rq2_rptr=Gray(5)=00111. Required: w_level=11, w_almost_full=0.
5. **Wrap.** Starting with rq2_rptr=Gray(20)=11110, drive wbin from 20 to 36 (mod 32 = 4).
   - Required: the pointer passes 31→0 with w_ptr 10000→00000.
   - Required: w_full asserts exactly when w_ptr=00110, and w_level=16.
6. **Simultaneous event.** At level 15, in one cycle, apply a write together with an rq2_rptr advance by one.
   - Required: level stays 15, w_full stays 0, and w_ptr advances by one Gray step.

Source files
------------

// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle of the async FIFO: write request plus synchronized read
// pointer in, RAM write strobe/address, Gray write pointer and status out.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  // Handshake: w_en is a request the producer may raise at any time. w_accept
  // is the same-cycle combinational grant. A word is written in exactly those
  // cycles where w_accept is 1. A request made while full is dropped, not
  // stalled, and it is recorded in w_overflow.
  logic                  w_en;
  logic [ADDR_WIDTH:0]   rq2_rptr;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH:0]   w_ptr;
  logic                  w_full;
  logic                  w_almost_full;
  logic [ADDR_WIDTH:0]   w_level;
  logic                  w_overflow;

  modport master (
    output w_en, rq2_rptr,
    input  w_accept, w_addr, w_ptr, w_full, w_almost_full, w_level, w_overflow
  );

  modport slave (
    input  w_en, rq2_rptr,
    output w_accept, w_addr, w_ptr, w_full, w_almost_full, w_level, w_overflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag controller of the async FIFO. It keeps the binary
// write pointer and a registered Gray copy, and derives full, level and overflow.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12
) (
  input logic              clk,
  input logic              rst,
  fifo_wptr_full_if.slave  wif
);
  localparam int A  = ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic          w_accept;
  logic [PW-1:0] wbin_d, wbin_q;
  logic [PW-1:0] w_ptr_d, w_ptr_q;
  logic [PW-1:0] w_level_d, w_level_q;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_ptr;
  logic          w_full_d, w_full_q;
  logic          w_af_d, w_af_q;
  logic          w_ovf_d, w_ovf_q;

  always_comb begin
    w_accept  = 1'b0;
    wbin_d    = wbin_q;
    w_ptr_d   = w_ptr_q;
    rbin      = '0;
    full_ptr  = '0;
    w_full_d  = w_full_q;
    w_level_d = w_level_q;
    w_af_d    = w_af_q;
    w_ovf_d   = w_ovf_q;

    w_accept = wif.w_en & ~w_full_q & ~rst;
    wbin_d   = wbin_q + {{A{1'b0}}, w_accept};
    w_ptr_d  = (wbin_d >> 1) ^ wbin_d;

    // Full when the write pointer has lapped the read pointer: the top two
    // Gray bits are inverted and the rest are equal.
    full_ptr = {~wif.rq2_rptr[A:A-1], wif.rq2_rptr[A-2:0]};
    w_full_d = (w_ptr_d == full_ptr);

    // Modulo subtraction stays correct across pointer wrap.
    rbin      = gray2bin(wif.rq2_rptr);
    w_level_d = wbin_d - rbin;
    w_af_d    = (w_level_d >= AF_T);

    w_ovf_d = w_ovf_q | (wif.w_en & w_full_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q    <= '0;
      w_ptr_q   <= '0;
      w_level_q <= '0;
      w_full_q  <= 1'b0;
      w_af_q    <= 1'b0;
      w_ovf_q   <= 1'b0;
    end else begin
      wbin_q    <= wbin_d;
      w_ptr_q   <= w_ptr_d;
      w_level_q <= w_level_d;
      w_full_q  <= w_full_d;
      w_af_q    <= w_af_d;
      w_ovf_q   <= w_ovf_d;
    end
  end

  assign wif.w_accept      = w_accept;
  assign wif.w_addr        = wbin_q[A-1:0];
  assign wif.w_ptr         = w_ptr_q;
  assign wif.w_full        = w_full_q;
  assign wif.w_almost_full = w_af_q;
  assign wif.w_level       = w_level_q;
  assign wif.w_overflow    = w_ovf_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_WIDTH=4, AF_THRESH=12): reset, fill,
// overflow, drain, pointer wrap and simultaneous write/read-advance.
module tb_fifo_wptr_full;
  logic clk;
  logic rst;

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_wptr_full_if #(.ADDR_WIDTH(4)) wif ();

  fifo_wptr_full #(.ADDR_WIDTH(4), .AF_THRESH(12)) dut (
    .clk (clk),
    .rst (rst),
    .wif (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected Gray codes for binary 0..16.
  logic [4:0] gray_tbl [0:16] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010,
                                  5'b00110, 5'b00111, 5'b00101, 5'b00100,
                                  5'b01100, 5'b01101, 5'b01111, 5'b01110,
                                  5'b01010, 5'b01011, 5'b01001, 5'b01000,
                                  5'b11000};

  function automatic logic [4:0] g5(input int x);
    logic [4:0] b;
    b = 5'(x);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int addr, input int ptr, input int lvl,
                           input bit af, input bit full, input bit ovf);
    chk({tag, ".addr"},  32'(wif.w_addr), 32'(addr));
    chk({tag, ".ptr"},   32'(wif.w_ptr), 32'(ptr));
    chk({tag, ".level"}, 32'(wif.w_level), 32'(lvl));
    chk({tag, ".af"},    32'(wif.w_almost_full), 32'(af));
    chk({tag, ".full"},  32'(wif.w_full), 32'(full));
    chk({tag, ".ovf"},   32'(wif.w_overflow), 32'(ovf));
  endtask

  initial begin
    logic [4:0] prev_ptr;

    // Reset held two cycles with a write request pending.
    rst = 1'b1;
    wif.w_en = 1'b1;
    wif.rq2_rptr = 5'b00000;
    #1;
    chk("rst.accept0", 32'(wif.w_accept), 32'd0);
    tick();
    chk_state("rst1", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("rst1.accept", 32'(wif.w_accept), 32'd0);
    tick();
    chk_state("rst2", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("rst2.accept", 32'(wif.w_accept), 32'd0);
    rst = 1'b0;
    #1;

    // Fill: 16 back-to-back writes with the read pointer parked at 0.
    prev_ptr = 5'b00000;
    for (int i = 0; i < 16; i++) begin
      chk("fill.accept", 32'(wif.w_accept), 32'd1);
      tick();
      chk_state("fill", (i + 1) % 16, int'(gray_tbl[i+1]), i + 1,
                (i + 1) >= 12, (i + 1) == 16, 1'b0);
      chk("fill.onebit", 32'($countones(wif.w_ptr ^ prev_ptr)), 32'd1);
      prev_ptr = wif.w_ptr;
    end

    // Overflow: keep requesting while full.
    for (int i = 0; i < 3; i++) begin
      chk("ovf.accept", 32'(wif.w_accept), 32'd0);
      tick();
      chk_state("ovf", 0, 5'b11000, 16, 1'b1, 1'b1, 1'b1);
    end
    wif.w_en = 1'b0;
    tick();
    chk("ovf.sticky", 32'(wif.w_overflow), 32'd1);

    // Drain: read pointer advances to 4, then 5.
    wif.rq2_rptr = 5'b00110;
    tick();
    chk_state("drain4", 0, 5'b11000, 12, 1'b1, 1'b0, 1'b1);
    wif.rq2_rptr = 5'b00111;
    tick();
    chk_state("drain5", 0, 5'b11000, 11, 1'b0, 1'b0, 1'b1);

    // Bring wbin to 20 and the read pointer to 20 (empty), then wrap.
    wif.rq2_rptr = 5'b01010;
    tick();
    chk("pre.level4", 32'(wif.w_level), 32'd4);
    wif.w_en = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) tick();
    wif.w_en = 1'b0;
    chk_state("pre20", 4, 5'b11110, 8, 1'b0, 1'b0, 1'b1);
    wif.rq2_rptr = 5'b11110;
    tick();
    chk_state("empty20", 4, 5'b11110, 0, 1'b0, 1'b0, 1'b1);

    wif.w_en = 1'b1;
    #1;
    for (int k = 1; k <= 16; k++) begin
      chk("wrap.accept", 32'(wif.w_accept), 32'd1);
      tick();
      chk_state("wrap", (20 + k) % 16, int'(g5(20 + k)), k, k >= 12, k == 16, 1'b1);
      if (k == 11) chk("wrap.ptr31", 32'(wif.w_ptr), 32'h10);
      if (k == 12) chk("wrap.ptr0", 32'(wif.w_ptr), 32'h00);
    end
    wif.w_en = 1'b0;
    #1;
    chk("wrap.full_ptr", 32'(wif.w_ptr), 32'h06);
    chk("wrap.full_accept", 32'(wif.w_accept), 32'd0);

    // Simultaneous: read advances to 21 (level 15), then write plus read to 22.
    wif.rq2_rptr = 5'b11111;
    tick();
    chk_state("sim.pre", 4, 5'b00110, 15, 1'b1, 1'b0, 1'b1);
    wif.w_en = 1'b1;
    wif.rq2_rptr = 5'b11101;
    #1;
    chk("sim.accept", 32'(wif.w_accept), 32'd1);
    tick();
    wif.w_en = 1'b0;
    chk_state("sim.post", 5, 5'b00111, 15, 1'b1, 1'b0, 1'b1);

    // Reset clears the sticky overflow and all pointer state.
    rst = 1'b1;
    tick();
    chk_state("rst.end", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("rst.end.ovf", 32'(wif.w_overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
